// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   state_e   FSM encoding (FETCH issues requests, DRAIN discards stale responses)
//   NOP_WORD  instruction presented while the queue is empty
//   PC_INC    sequential fetch increment
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x W synchronous FIFO with async reset and synchronous flush.
// Ports:
//   clk, rst   clock / async active-high reset
//   flush_i    empty the queue this edge (beats push and pop)
//   push_i     write wdata_i at tail (caller guarantees not full unless popping)
//   pop_i      drop head (caller guarantees not empty)
//   wdata_i    entry to push
//   rdata_o    head entry (storage is not reset; qualify with count_o != 0)
//   count_o    registered occupancy
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    // Power-of-two depth: pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with prefetch queue and redirect handling.
// Optional feature macro: FETCH_PERF_EN (adds perf_fetched / perf_dropped counters).
// Ports:
//   clk, reset                 clock / async active-high reset
//   redirect_en, redirect_pc   taken branch/jump from MEM; flushes and restarts fetch
//   imem_req/addr/gnt          in-order word read request channel
//   imem_rvalid/rdata          in-order read responses
//   out_valid/ready            head handshake toward IF/ID
//   out_instr, out_pcplus4     head instruction and its address + 4
//   perf_fetched, perf_dropped (FETCH_PERF_EN only) saturating event counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pcplus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH+1);

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;   // address of the next expected response
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          req_q, req_d;

    logic [CW-1:0] cnt, cnt_d, pending;
    logic [63:0]   head;
    logic          issue, rsp_fetch, push, pop;
    logic [31:0]   redir_addr;

    assign issue      = req_q & imem_gnt;
    assign rsp_fetch  = imem_rvalid & (state_q == FETCH);
    assign push       = rsp_fetch & ~redirect_en;
    assign pop        = out_valid & out_ready & ~redirect_en;
    assign redir_addr = redirect_pc & ~32'd3;
    // Everything still owed by memory after this cycle; only one of outst/drop is nonzero.
    assign pending    = outst_q + drop_q + CW'(issue) - CW'(imem_rvalid);
    assign cnt_d      = redirect_en ? '0 : cnt + CW'(push) - CW'(pop);

    fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .flush_i (redirect_en),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({imem_rdata, rsp_pc_q + PC_INC}),
        .rdata_o (head),
        .count_o (cnt)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        if (redirect_en) begin
            // Everything in flight, including this cycle's issue, becomes stale.
            pc_d     = redir_addr;
            rsp_pc_d = redir_addr;
            outst_d  = '0;
            drop_d   = pending;
            state_d  = (pending != '0) ? DRAIN : FETCH;
        end else if (state_q == FETCH) begin
            if (issue)     pc_d     = pc_q + PC_INC;
            if (rsp_fetch) rsp_pc_d = rsp_pc_q + PC_INC;
            outst_d = outst_q + CW'(issue) - CW'(imem_rvalid);
        end else if (imem_rvalid) begin
            drop_d = drop_q - 1'b1;
            if (drop_q == CW'(1)) state_d = FETCH;
        end
        // Registered request from next-state counts: a pop frees credit next cycle.
        req_d = (state_d == FETCH) &&
                (({1'b0, cnt_d} + {1'b0, outst_d}) < (CW+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            req_q    <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign out_valid   = (cnt != '0);
    assign out_instr   = out_valid ? head[63:32] : NOP_WORD;
    assign out_pcplus4 = out_valid ? head[31:0]  : 32'h0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_dropped_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            if (pop && perf_fetched_q != '1)
                perf_fetched_q <= perf_fetched_q + 1'b1;
            if (imem_rvalid && state_q == DRAIN && perf_dropped_q != '1)
                perf_dropped_q <= perf_dropped_q + 1'b1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule
